// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stage and its consumers: monitor FSM
// encodings, default width and the maximal 8-bit period constant.
package lfsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } mon_state_t;

    localparam int unsigned LFSR_WIDTH         = 8;
    localparam int unsigned LFSR_MAX_PERIOD_W8 = 255;

endpackage

// File: rtl/lfsr_seen_map.sv
// One-bit-per-value bitmap recording which LFSR values have been observed;
// synchronous clear and set, combinational query.
module lfsr_seen_map #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             set_en,
    input  logic [WIDTH-1:0] set_addr,
    input  logic [WIDTH-1:0] query_addr,
    output logic             hit
);

    logic [(2**WIDTH)-1:0] map_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_q <= '0;
        end else if (clr) begin
            map_q <= '0;
        end else if (set_en) begin
            map_q[set_addr] <= 1'b1;
        end
    end

    assign hit = map_q[query_addr];

endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the period of an LFSR stream: latches the first valid sample as seed
// and counts valid samples until it returns. Optional duplicate detection via LFSR_PERIOD_MON_DUP_EN.
module lfsr_period_monitor
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_WIDTH,
    parameter int unsigned CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [WIDTH-1:0] seed,
    output logic             err_zero,
    output logic             err_timeout,
    output logic             err_dup
);

    // Counter value at which the next non-matching sample is the 2^WIDTH-th.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WIDTH) - 1);

    mon_state_t       state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [WIDTH-1:0] seed_q, seed_nxt;
    logic [CNT_W-1:0] period_q, period_nxt;
    logic             done_q, done_nxt;
    logic             ez_q, ez_nxt;
    logic             et_q, et_nxt;

`ifdef LFSR_PERIOD_MON_DUP_EN
    logic ed_q, ed_nxt;
    logic map_clr, map_set, map_hit;

    lfsr_seen_map #(.WIDTH(WIDTH)) u_seen_map (
        .clk        (clk),
        .rst        (rst),
        .clr        (map_clr),
        .set_en     (map_set),
        .set_addr   (sample),
        .query_addr (sample),
        .hit        (map_hit)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            seed_q   <= '0;
            period_q <= '0;
            done_q   <= 1'b0;
            ez_q     <= 1'b0;
            et_q     <= 1'b0;
`ifdef LFSR_PERIOD_MON_DUP_EN
            ed_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            seed_q   <= seed_nxt;
            period_q <= period_nxt;
            done_q   <= done_nxt;
            ez_q     <= ez_nxt;
            et_q     <= et_nxt;
`ifdef LFSR_PERIOD_MON_DUP_EN
            ed_q     <= ed_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        seed_nxt   = seed_q;
        period_nxt = period_q;
        done_nxt   = done_q;
        ez_nxt     = ez_q;
        et_nxt     = et_q;
`ifdef LFSR_PERIOD_MON_DUP_EN
        ed_nxt     = ed_q;
        map_clr    = 1'b0;
        map_set    = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt  = ST_CAPTURE;
                    cnt_nxt    = '0;
                    period_nxt = '0;
                    done_nxt   = 1'b0;
                    ez_nxt     = 1'b0;
                    et_nxt     = 1'b0;
`ifdef LFSR_PERIOD_MON_DUP_EN
                    ed_nxt     = 1'b0;
                    map_clr    = 1'b1;
`endif
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    if (sample == '0) begin
                        ez_nxt    = 1'b1;
                        state_nxt = ST_ERR;
                    end else begin
                        seed_nxt  = sample;
                        cnt_nxt   = '0;
                        state_nxt = ST_RUN;
`ifdef LFSR_PERIOD_MON_DUP_EN
                        map_set   = 1'b1;
`endif
                    end
                end
            end
            ST_RUN: begin
                if (sample_valid) begin
                    if (sample == '0) begin
                        ez_nxt    = 1'b1;
                        state_nxt = ST_ERR;
                    end
`ifdef LFSR_PERIOD_MON_DUP_EN
                    else if (map_hit && (sample != seed_q)) begin
                        ed_nxt    = 1'b1;
                        state_nxt = ST_ERR;
                    end
`endif
                    else if (sample == seed_q) begin
                        period_nxt = cnt_q + CNT_W'(1);
                        done_nxt   = 1'b1;
                        state_nxt  = ST_DONE;
                    end else if (cnt_q == LAST_CNT) begin
                        et_nxt    = 1'b1;
                        state_nxt = ST_ERR;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
`ifdef LFSR_PERIOD_MON_DUP_EN
                        map_set = 1'b1;
`endif
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy        = (state_q == ST_CAPTURE) || (state_q == ST_RUN);
    assign done        = done_q;
    assign period      = period_q;
    assign seed        = seed_q;
    assign err_zero    = ez_q;
    assign err_timeout = et_q;
`ifdef LFSR_PERIOD_MON_DUP_EN
    assign err_dup     = ed_q;
`else
    assign err_dup     = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor; expectations follow the build's
// LFSR_PERIOD_MON_DUP_EN setting.
module tb_lfsr_period_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sample = '0;
    logic       sample_valid = 1'b0;
    logic       busy, done, err_zero, err_timeout, err_dup;
    logic [8:0] period;
    logic [7:0] seed;

    int total = 0;
    int bad   = 0;

    lfsr_period_monitor #(.WIDTH(8), .CNT_W(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done),
        .period       (period),
        .seed         (seed),
        .err_zero     (err_zero),
        .err_timeout  (err_timeout),
        .err_dup      (err_dup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied 1 time unit after the previous edge, outputs settled 1 after this one.
    task automatic cyc(input logic st, input logic v, input logic [7:0] s);
        start        = st;
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        #1;
        start        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
    endtask

    // Fibonacci LFSR, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1).
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk_errs(input string tag, input logic z, input logic t, input logic d);
        chk({tag, "_err_zero"}, {31'd0, err_zero}, {31'd0, z});
        chk({tag, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, t});
        chk({tag, "_err_dup"}, {31'd0, err_dup}, {31'd0, d});
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] v;

        // ---- reset ----
        #2 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_period", {23'd0, period}, 0);
        chk("rst_seed", {24'd0, seed}, 0);
        chk_errs("rst", 0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0);

        // ---- maximal LFSR from seed 1 ----
        cyc(1, 0, 0);
        chk("t1_busy_capture", {31'd0, busy}, 1);
        s = 8'd1;
        cyc(0, 1, s);
        chk("t1_seed", {24'd0, seed}, 1);
        for (int i = 1; i <= 254; i++) begin
            s = lfsr_next(s);
            cyc(0, 1, s);
        end
        chk("t1_not_done_254", {31'd0, done}, 0);
        chk("t1_busy_254", {31'd0, busy}, 1);
        s = lfsr_next(s);
        chk("t1_model_returns", {24'd0, s}, 1);
        cyc(0, 1, s);
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_period", {23'd0, period}, 255);
        chk("t1_busy_off", {31'd0, busy}, 0);
        chk_errs("t1", 0, 0, 0);
        cyc(0, 1, 8'd9);
        cyc(0, 0, 0);
        chk("t1_hold_period", {23'd0, period}, 255);
        chk("t1_hold_done", {31'd0, done}, 1);

        // ---- 1,2,3,1 with gaps; start+valid together is not captured ----
        cyc(1, 1, 8'd2);
        chk("t2_cleared_done", {31'd0, done}, 0);
        chk("t2_cleared_period", {23'd0, period}, 0);
        cyc(0, 1, 8'd1);
        cyc(0, 0, 8'd1);
        cyc(0, 1, 8'd2);
        cyc(0, 0, 8'd1);
        cyc(0, 0, 8'd7);
        cyc(0, 1, 8'd3);
        cyc(0, 0, 8'd1);
        chk("t2_not_done", {31'd0, done}, 0);
        cyc(0, 1, 8'd1);
        chk("t2_seed", {24'd0, seed}, 1);
        chk("t2_done", {31'd0, done}, 1);
        chk("t2_period", {23'd0, period}, 3);

        // ---- zero after seed ----
        cyc(1, 0, 0);
        cyc(0, 1, 8'd5);
        cyc(0, 0, 0);
        cyc(0, 1, 8'd0);
        chk("t3_seed", {24'd0, seed}, 5);
        chk("t3_busy", {31'd0, busy}, 0);
        chk("t3_done", {31'd0, done}, 0);
        chk("t3_period", {23'd0, period}, 0);
        chk_errs("t3", 1, 0, 0);
        cyc(0, 1, 8'd5);
        chk("t3_hold_err", {31'd0, err_zero}, 1);
        chk("t3_hold_busy", {31'd0, busy}, 0);

        // ---- timeout: seed 7, values 1..255 except 7, wrapping ----
        cyc(1, 0, 0);
        chk("t4_cleared_ez", {31'd0, err_zero}, 0);
        cyc(0, 1, 8'd7);
        for (int i = 0; i < 255; i++) begin
            v = 8'((i % 254) + 1);
            if (v >= 8'd7) v = v + 8'd1;
            cyc(0, 1, v);
        end
`ifdef LFSR_PERIOD_MON_DUP_EN
        chk("t4_dup_on_wrap", {31'd0, err_dup}, 1);
        chk("t4_busy", {31'd0, busy}, 0);
        chk_errs("t4", 0, 0, 1);
`else
        chk("t4_busy_255", {31'd0, busy}, 1);
        chk("t4_no_timeout_255", {31'd0, err_timeout}, 0);
        cyc(0, 1, 8'd3);
        chk("t4_busy_256", {31'd0, busy}, 0);
        chk_errs("t4", 0, 1, 0);
        chk("t4_done", {31'd0, done}, 0);
`endif

        // ---- stream 9,4,6,4 ----
        cyc(1, 0, 0);
        cyc(0, 1, 8'd9);
        cyc(0, 1, 8'd4);
        cyc(0, 1, 8'd6);
        cyc(0, 1, 8'd4);
`ifdef LFSR_PERIOD_MON_DUP_EN
        chk("t5_busy", {31'd0, busy}, 0);
        chk_errs("t5", 0, 0, 1);
`else
        chk("t5_busy_3", {31'd0, busy}, 1);
        chk("t5_dup_tied", {31'd0, err_dup}, 0);
        for (int i = 4; i <= 256; i++) begin
            cyc(0, 1, (i % 2 == 0) ? 8'd4 : 8'd6);
            if (i == 255) chk("t5_no_timeout_255", {31'd0, err_timeout}, 0);
        end
        chk("t5_busy_256", {31'd0, busy}, 0);
        chk_errs("t5", 0, 1, 0);
`endif

        // ---- async reset at count 100 ----
        cyc(1, 0, 0);
        s = 8'd1;
        cyc(0, 1, s);
        for (int i = 1; i <= 100; i++) begin
            s = lfsr_next(s);
            cyc(0, 1, s);
        end
        chk("t6_busy_mid", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_seed", {24'd0, seed}, 0);
        chk("t6_rst_done", {31'd0, done}, 0);
        chk("t6_rst_period", {23'd0, period}, 0);
        chk_errs("t6_rst", 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- rerun full stream, start pulsed mid-RUN is ignored ----
        cyc(1, 0, 0);
        s = 8'd1;
        cyc(0, 1, s);
        for (int i = 1; i <= 255; i++) begin
            s = lfsr_next(s);
            cyc(i == 50, 1, s);
        end
        chk("t6_done", {31'd0, done}, 1);
        chk("t6_period", {23'd0, period}, 255);
        chk("t6_seed", {24'd0, seed}, 1);
        chk_errs("t6", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
